// File: rtl/gaplus_sprite_linesel_pkg.sv
// Shared definitions for the per-line sprite selector: attribute field
// positions, default visibility constants and the scan FSM encoding.
package gaplus_sprite_linesel_pkg;

    // Attribute word 0 fields
    localparam int W0_CODE_LSB = 0;
    localparam int W0_CODE_MSB = 7;
    localparam int W0_Y_LSB    = 8;
    localparam int W0_Y_MSB    = 15;
    localparam int W0_TALL     = 21;

    // Attribute word 1 fields
    localparam int W1_X_LSB    = 8;
    localparam int W1_X_MSB    = 16;
    localparam int W1_DIS      = 17;

    // Visibility defaults
    localparam int         VOFS_DEFAULT   = 27;
    localparam logic [7:0] HIDE_Y_DEFAULT = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RD0   = 3'd2,
        ST_RD1   = 3'd3,
        ST_EVAL  = 3'd4,
        ST_TEST  = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

endpackage

// File: rtl/gaplus_sprite_linesel_vtest.sv
// Combinational visibility test for one sprite against the current line,
// also producing the row within the sprite that the line falls on.
module gaplus_sprite_vtest
    import gaplus_sprite_linesel_pkg::*;
#(
    parameter int         VOFS   = VOFS_DEFAULT,
    parameter logic [7:0] HIDE_Y = HIDE_Y_DEFAULT
) (
    input  logic [7:0]  vline,
    input  logic [23:0] word0,
    input  logic [23:0] word1,
    output logic        visible,
    output logic [4:0]  row
);

    logic [7:0] y;
    logic [7:0] nvt;
    logic [8:0] x;
    logic       tall;
    logic       dis;
    logic       in_band;
    logic [28:0] unused_bits;

    assign unused_bits = {word0[23:22], word0[20:16], word0[W0_CODE_MSB:W0_CODE_LSB],
                          word1[23:18], word1[7:0]};

    // Line offset into the sprite, 8-bit wrap; tall sprites span 32 lines, others 16
    always_comb begin
        y       = word0[W0_Y_MSB:W0_Y_LSB];
        tall    = word0[W0_TALL];
        x       = word1[W1_X_MSB:W1_X_LSB];
        dis     = word1[W1_DIS];
        nvt     = vline + y + 8'(VOFS);
        in_band = tall ? (nvt[7:5] == 3'b111) : (nvt[7:4] == 4'hF);
        visible = ~dis && (y != HIDE_Y) && (x != '0) && in_band;
        row     = nvt[4:0];
    end

endmodule

// File: rtl/gaplus_sprite_linesel.sv
// Per-line sprite selector: on each HB rising edge, clears one bank of the
// line work RAM, scans all attribute entries and copies the visible ones
// (up to MAX_PER_LINE) into that bank while the renderer reads the other.
module gaplus_sprite_linesel
    import gaplus_sprite_linesel_pkg::*;
#(
    parameter int         NUM_SPR      = 64,
    parameter int         MAX_PER_LINE = 32,
    parameter int         VOFS         = VOFS_DEFAULT,
    parameter logic [7:0] HIDE_Y       = HIDE_Y_DEFAULT,
    parameter bit         STOP_ON_FULL = 1'b0,
    localparam int        IW           = $clog2(NUM_SPR),
    localparam int        SW           = $clog2(MAX_PER_LINE)
) (
    input  logic          VCLKx4,
    input  logic          RST_N,
    input  logic          HB,
    input  logic [8:0]    VPOS,
    output logic [IW:0]   SPRA_A,
    input  logic [23:0]   SPRA_D,
    output logic [SW:0]   WR_A,
    output logic [28:0]   WR_D0,
    output logic [23:0]   WR_D1,
    output logic          WR_WE,
    output logic          RBANK,
    output logic [SW:0]   COUNT,
    output logic          OVF,
    output logic          BUSY,
    output logic          DONE
);

    state_t        state, state_n;
    logic          hb_d, hb_start;
    logic          wbank;
    logic [IW-1:0] idx;
    logic [SW:0]   slot;
    logic [SW-1:0] clr;
    logic          ovf_flag;
    logic [7:0]    vline;
    logic [23:0]   w0, w1;
    logic [SW:0]   count_q;
    logic          ovf_q, done_q;
    logic          visible;
    logic [4:0]    row;
    logic          slot_full;
    logic          unused_vpos_msb;

    assign unused_vpos_msb = VPOS[8];
    assign slot_full       = slot[SW];

    gaplus_sprite_vtest #(
        .VOFS   (VOFS),
        .HIDE_Y (HIDE_Y)
    ) u_vtest (
        .vline   (vline),
        .word0   (w0),
        .word1   (w1),
        .visible (visible),
        .row     (row)
    );

    // Scan state register
    always_ff @(posedge VCLKx4 or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state and work-RAM/attribute bus drive; an HB edge overrides everything
    always_comb begin
        state_n = state;
        SPRA_A  = {idx, state == ST_RD1};
        WR_A    = {wbank, slot[SW-1:0]};
        WR_D0   = '0;
        WR_D1   = '0;
        WR_WE   = 1'b0;
        if (hb_start) begin
            state_n = ST_CLEAR;
        end else begin
            case (state)
                ST_IDLE:  state_n = ST_IDLE;
                ST_CLEAR: begin
                    WR_A  = {wbank, clr};
                    WR_WE = 1'b1;
                    if (clr == SW'(MAX_PER_LINE - 1)) state_n = ST_RD0;
                end
                ST_RD0:   state_n = ST_RD1;
                ST_RD1:   state_n = ST_EVAL;
                ST_EVAL:  state_n = ST_TEST;
                ST_TEST: begin
                    if (visible && !slot_full) begin
                        WR_D0 = {row, w0};
                        WR_D1 = w1;
                        WR_WE = 1'b1;
                    end
                    if (visible && slot_full && STOP_ON_FULL) state_n = ST_FIN;
                    else if (idx == IW'(NUM_SPR - 1))           state_n = ST_FIN;
                    else                                        state_n = ST_RD0;
                end
                ST_FIN:   state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // Edge detect, bank/slot bookkeeping, attribute latching and result capture
    always_ff @(posedge VCLKx4 or negedge RST_N) begin
        if (!RST_N) begin
            hb_d     <= 1'b0;
            hb_start <= 1'b0;
            wbank    <= 1'b0;
            idx      <= '0;
            slot     <= '0;
            clr      <= '0;
            ovf_flag <= 1'b0;
            vline    <= '0;
            w0       <= '0;
            w1       <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            hb_d     <= HB;
            hb_start <= HB & ~hb_d;
            done_q   <= 1'b0;
            if (hb_start) begin
                // An interrupted scan still publishes what it had selected so far
                if (state != ST_IDLE) begin
                    count_q <= slot;
                    ovf_q   <= ovf_flag;
                end
                wbank    <= ~wbank;
                slot     <= '0;
                clr      <= '0;
                idx      <= '0;
                ovf_flag <= 1'b0;
                vline    <= VPOS[7:0];
            end else begin
                case (state)
                    ST_CLEAR: clr <= clr + SW'(1);
                    ST_RD1:   w0  <= SPRA_D;
                    ST_EVAL:  w1  <= SPRA_D;
                    ST_TEST: begin
                        if (visible) begin
                            if (!slot_full) slot     <= slot + (SW + 1)'(1);
                            else            ovf_flag <= 1'b1;
                        end
                        if (state_n == ST_RD0) idx <= idx + IW'(1);
                    end
                    ST_FIN: begin
                        count_q <= slot;
                        ovf_q   <= ovf_flag;
                        done_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RBANK = ~wbank;
    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign BUSY  = (state != ST_IDLE);
    assign DONE  = done_q;

endmodule
